// File: rtl/loa_accumulator_if.sv
// rtl/loa_accumulator_if.sv - operand beat stream in, frame result stream out, for loa_accumulator
interface loa_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/loa_accumulator.sv
// rtl/loa_accumulator.sv - frame accumulator using lower-part-OR approximate adds; optional LOA_EXACT_MODE_EN adds exact_mode
module loa_accumulator #(
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 24,
  parameter int APPROX = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
`ifdef LOA_EXACT_MODE_EN
  input logic exact_mode,
`endif
  loa_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Bits below APPROX are produced by OR; APX_IDX is the top approximate bit that feeds the carry.
  localparam logic [ACC_W-1:0] LOW_MASK = {ACC_W{1'b1}} >> (ACC_W - APPROX);
  localparam int               APX_IDX  = (APPROX > 0) ? APPROX - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Returns {carry_out, sum}. With use_loa low (or APPROX=0) the add is exact.
  function automatic logic [ACC_W:0] loa_add(
    input logic [ACC_W-1:0] x,
    input logic [ACC_W-1:0] y,
    input logic             use_loa
  );
    logic [ACC_W:0]   exact_sum;
    logic [ACC_W:0]   hi_sum;
    logic [ACC_W-1:0] lo_bits;
    logic             carry_in;
    exact_sum = {1'b0, x} + {1'b0, y};
    carry_in  = x[APX_IDX] & y[APX_IDX];
    // Masked operands leave the low bits of hi_sum at zero, so OR-ing the approximate part in is safe.
    hi_sum    = {1'b0, x & ~LOW_MASK} + {1'b0, y & ~LOW_MASK}
              + ((ACC_W+1)'(carry_in) << APPROX);
    lo_bits   = (x | y) & LOW_MASK;
    if (use_loa && (APPROX > 0)) begin
      return hi_sum | {1'b0, lo_bits};
    end
    return exact_sum;
  endfunction

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] res_sum_q, res_sum_d;
  logic             res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             in_ready_w;
  logic             out_valid_w;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] in_data_w;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   add_res;
  logic             first_loa;
  logic             frame_loa;

`ifdef LOA_EXACT_MODE_EN
  logic exact_q, exact_d;
  // The mode is taken from the port on a frame's first beat and from the latch afterwards.
  assign first_loa = ~exact_mode;
  assign frame_loa = ~exact_q;
`else
  assign first_loa = 1'b1;
  assign frame_loa = 1'b1;
`endif

  assign in_data_w = bus.in_data;
  assign operand   = ACC_W'(in_data_w);

  // Next-state, accumulate and result-capture logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    res_cnt_d   = res_cnt_q;
    add_res     = '0;
`ifdef LOA_EXACT_MODE_EN
    exact_d     = exact_q;
`endif
    in_ready_w  = (state_q != ST_HOLD);
    out_valid_w = (state_q == ST_HOLD);
    accept      = bus.in_valid & in_ready_w;
    deliver     = out_valid_w & bus.out_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          add_res = loa_add('0, operand, first_loa);
          acc_d   = add_res[ACC_W-1:0];
          ovf_d   = 1'b0;
          count_d = CNT_W'(1);
`ifdef LOA_EXACT_MODE_EN
          exact_d = exact_mode;
`endif
          if (bus.in_last) begin
            state_d   = ST_HOLD;
            res_sum_d = acc_d;
            res_ovf_d = ovf_d;
            res_cnt_d = count_d;
          end else begin
            state_d = ST_ACC;
          end
        end
      end

      ST_ACC: begin
        if (accept) begin
          add_res = loa_add(acc_q, operand, frame_loa);
          acc_d   = add_res[ACC_W-1:0];
          ovf_d   = ovf_q | add_res[ACC_W];
          count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d   = ST_HOLD;
            res_sum_d = acc_d;
            res_ovf_d = ovf_d;
            res_cnt_d = count_d;
          end
        end
      end

      ST_HOLD: begin
        // No accept here: the beat after a handoff waits for the IDLE cycle.
        if (deliver) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      res_sum_q <= '0;
      res_ovf_q <= 1'b0;
      res_cnt_q <= '0;
`ifdef LOA_EXACT_MODE_EN
      exact_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      res_sum_q <= res_sum_d;
      res_ovf_q <= res_ovf_d;
      res_cnt_q <= res_cnt_d;
`ifdef LOA_EXACT_MODE_EN
      exact_q   <= exact_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_sum   = res_sum_q;
  assign bus.out_ovf   = res_ovf_q;
  assign bus.out_count = res_cnt_q;

endmodule

// File: tb/tb_loa_accumulator.sv
// tb/tb_loa_accumulator.sv - self-checking bench for loa_accumulator (24-bit and 16-bit/2-bit-count instances)
`timescale 1ns/1ps
module tb_loa_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        v;
  logic [15:0] d;
  logic        lst;
  logic        ordy;
  logic        em;
  int          vectors;
  int          miscompares;

  always #5 clk = ~clk;

  loa_accumulator_if #(.WIDTH(16), .ACC_W(24), .CNT_W(16)) bus_a ();
  loa_accumulator_if #(.WIDTH(16), .ACC_W(16), .CNT_W(2))  bus_b ();

  assign bus_a.in_valid  = v & (sel == 0);
  assign bus_a.in_data   = d;
  assign bus_a.in_last   = lst;
  assign bus_a.out_ready = ordy & (sel == 0);
  assign bus_b.in_valid  = v & (sel == 1);
  assign bus_b.in_data   = d;
  assign bus_b.in_last   = lst;
  assign bus_b.out_ready = ordy & (sel == 1);

  loa_accumulator #(.WIDTH(16), .ACC_W(24), .APPROX(8), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
`ifdef LOA_EXACT_MODE_EN
    .exact_mode (em),
`endif
    .bus (bus_a)
  );

  loa_accumulator #(.WIDTH(16), .ACC_W(16), .APPROX(8), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
`ifdef LOA_EXACT_MODE_EN
    .exact_mode (em),
`endif
    .bus (bus_b)
  );

  typedef struct packed {
    logic [3:0]   n;
    logic [127:0] d;
    logic [23:0]  sum;
    logic         ovf;
    logic [15:0]  cnt;
  } vec_t;

  function automatic logic cur_in_ready();
    return (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction
  function automatic logic cur_out_valid();
    return (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
  endfunction
  function automatic logic [63:0] cur_sum();
    return (sel == 0) ? 64'(bus_a.out_sum) : 64'(bus_b.out_sum);
  endfunction
  function automatic logic cur_ovf();
    return (sel == 0) ? bus_a.out_ovf : bus_b.out_ovf;
  endfunction
  function automatic logic [63:0] cur_cnt();
    return (sel == 0) ? 64'(bus_a.out_count) : 64'(bus_b.out_count);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference add: arithmetic on the split operands, then a single wrap at acc_w bits.
  function automatic void model_add(input longint unsigned x, input longint unsigned y,
                                    input int acc_w, input int apx,
                                    output longint unsigned s, output bit c);
    longint unsigned base, lo, hi, cin, full;
    base = 64'd1 << apx;
    lo   = (x | y) % base;
    cin  = (apx > 0) ? (((x >> (apx - 1)) & (y >> (apx - 1))) & 64'd1) : 64'd0;
    hi   = (x >> apx) + (y >> apx) + cin;
    full = hi * base + lo;
    c    = ((full >> acc_w) != 0);
    s    = full % (64'd1 << acc_w);
  endfunction

  task automatic model_frame(input int acc_w, input int apx, input int cnt_w, input int n,
                             input logic [127:0] dd, output logic [63:0] s, output logic o,
                             output logic [63:0] c);
    longint unsigned acc, nxt, cmax;
    bit cy;
    acc = 0;
    o   = 1'b0;
    for (int i = 0; i < n; i++) begin
      model_add(acc, 64'(dd[i*16 +: 16]), acc_w, apx, nxt, cy);
      if (i > 0) o = o | cy;
      acc = nxt;
    end
    cmax = (64'd1 << cnt_w) - 1;
    s = acc;
    c = (longint'(n) > cmax) ? cmax : 64'(n);
  endtask

  task automatic send(input logic [15:0] data, input logic last);
    v = 1'b1; d = data; lst = last;
    step();
    v = 1'b0; lst = 1'b0;
  endtask

  // Drives one frame with optional gaps; lat counts cycles from last accept to out_valid.
  task automatic run_frame(input int s, input int n, input logic [127:0] dd, input bit ex,
                           input int gaps, input int hold,
                           output logic [63:0] sum, output logic ovf, output logic [63:0] cnt,
                           output bit ok, output int lat);
    int t;
    bit r;
    ok  = 1'b1;
    sel = s;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gaps)) step();
      v   = 1'b1;
      d   = dd[i*16 +: 16];
      lst = (i == n - 1);
      em  = (i == 0) ? ex : 1'($urandom);
      t   = 0;
      do begin
        r = cur_in_ready();
        step();
        t++;
      end while (!r && t < 20);
      if (!r) ok = 1'b0;
      v = 1'b0; lst = 1'b0;
    end
    lat = 0;
    while (!cur_out_valid() && lat < 20) begin
      step();
      lat++;
    end
    if (!cur_out_valid()) ok = 1'b0;
    repeat (hold) step();
    sum = cur_sum();
    ovf = cur_ovf();
    cnt = cur_cnt();
    ordy = 1'b1;
    step();
    ordy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    logic [63:0] s_act, c_act, s_exp, c_exp;
    logic        o_act, o_exp;
    bit          ok;
    int          lat, n, s, hold;
    bit          ex;
    logic [127:0] dd;
    int          stray;

    vectors = 0; miscompares = 0;
    v = 0; d = '0; lst = 0; ordy = 0; em = 0; sel = 0; rst = 1'b1;

    tbl[0] = '{n: 4'd2, d: 128'h0001_00FF,           sum: 24'h0000FF, ovf: 1'b0, cnt: 16'd2};
    tbl[1] = '{n: 4'd2, d: 128'h0080_0080,           sum: 24'h000180, ovf: 1'b0, cnt: 16'd2};
    tbl[2] = '{n: 4'd1, d: 128'h1234,                sum: 24'h001234, ovf: 1'b0, cnt: 16'd1};
    tbl[3] = '{n: 4'd3, d: 128'hFFFF_FFFF_FFFF,      sum: 24'h02FFFF, ovf: 1'b0, cnt: 16'd3};
    tbl[4] = '{n: 4'd4, d: 128'h1000_0101_00F0_0F0F, sum: 24'h0020FF, ovf: 1'b0, cnt: 16'd4};
    tbl[5] = '{n: 4'd1, d: 128'hFFFF,                sum: 24'h00FFFF, ovf: 1'b0, cnt: 16'd1};

    step();
    step();
    for (int k = 0; k < 2; k++) begin
      sel = k;
      check("reset_in_ready",  64'(cur_in_ready()),  64'd1);
      check("reset_out_valid", 64'(cur_out_valid()), 64'd0);
      check("reset_sum",       cur_sum(),            64'd0);
      check("reset_ovf",       64'(cur_ovf()),       64'd0);
      check("reset_count",     cur_cnt(),            64'd0);
    end
    rst = 1'b0;
    step();

    for (int k = 0; k < 6; k++) begin
      run_frame(0, int'(tbl[k].n), tbl[k].d, 1'b0, 0, 0, s_act, o_act, c_act, ok, lat);
      check("tbl_handshake", 64'(ok),    64'd1);
      check("tbl_latency",   64'(lat),   64'd0);
      check("tbl_sum",       s_act,      64'(tbl[k].sum));
      check("tbl_ovf",       64'(o_act), 64'(tbl[k].ovf));
      check("tbl_count",     c_act,      64'(tbl[k].cnt));
    end

`ifdef LOA_EXACT_MODE_EN
    run_frame(0, 2, 128'h0001_00FF, 1'b1, 0, 0, s_act, o_act, c_act, ok, lat);
    check("exact_mode_sum", s_act, 64'h000100);
`endif

    // Carry out of the MSB on the 16-bit instance, then a clean frame.
    run_frame(1, 2, 128'h0100_FF00, 1'b0, 0, 0, s_act, o_act, c_act, ok, lat);
    check("ovf_sum",   s_act,      64'h0000);
    check("ovf_flag",  64'(o_act), 64'd1);
    check("ovf_count", c_act,      64'd2);
    run_frame(1, 1, 128'h0001, 1'b0, 0, 0, s_act, o_act, c_act, ok, lat);
    check("ovf_cleared", 64'(o_act), 64'd0);
    check("ovf_next_sum", s_act,     64'd1);

    // 2-bit count saturates at 3.
    run_frame(1, 5, 128'h0001_0001_0001_0001_0001, 1'b0, 1, 0, s_act, o_act, c_act, ok, lat);
    check("sat_count", c_act, 64'd3);
    check("sat_sum",   s_act, 64'd1);

    // Result held for 3 cycles with a stray beat offered; it must not be taken.
    sel = 0;
    send(16'h0080, 1'b0);
    send(16'h0080, 1'b1);
    v = 1'b1; d = 16'h5555; lst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("hold_out_valid", 64'(cur_out_valid()), 64'd1);
      check("hold_in_ready",  64'(cur_in_ready()),  64'd0);
      check("hold_sum",       cur_sum(),            64'h000180);
      check("hold_count",     cur_cnt(),            64'd2);
      step();
    end
    v = 1'b0; lst = 1'b0;
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    check("release_out_valid", 64'(cur_out_valid()), 64'd0);
    check("release_in_ready",  64'(cur_in_ready()),  64'd1);
    step();
    check("idle_sum_held",   cur_sum(),            64'h000180);
    check("idle_out_valid",  64'(cur_out_valid()), 64'd0);

    // Reset mid-frame discards the partial result.
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", 64'(cur_in_ready()), 64'd1);
    check("midrst_sum",      cur_sum(),           64'd0);
    check("midrst_count",    cur_cnt(),           64'd0);
    stray = 0;
    repeat (5) begin
      if (cur_out_valid()) stray++;
      step();
    end
    check("midrst_no_output", 64'(stray), 64'd0);
    run_frame(0, 1, 128'h1234, 1'b0, 0, 0, s_act, o_act, c_act, ok, lat);
    check("post_rst_sum",   s_act, 64'h001234);
    check("post_rst_count", c_act, 64'd1);

    // Reset while a result is held drops it.
    sel = 1;
    send(16'h00AA, 1'b1);
    rst = 1'b1; ordy = 1'b1;
    step();
    rst = 1'b0; ordy = 1'b0;
    check("holdrst_out_valid", 64'(cur_out_valid()), 64'd0);
    check("holdrst_sum",       cur_sum(),            64'd0);

    // Random frames on both instances against the reference model.
    for (int k = 0; k < 60; k++) begin
      s    = k % 2;
      n    = $urandom_range(1, 8);
      dd   = {$urandom, $urandom, $urandom, $urandom};
      hold = $urandom_range(0, 3);
`ifdef LOA_EXACT_MODE_EN
      ex = 1'($urandom);
`else
      ex = 1'b0;
`endif
      run_frame(s, n, dd, ex, 2, hold, s_act, o_act, c_act, ok, lat);
      if (s == 0) model_frame(24, ex ? 0 : 8, 16, n, dd, s_exp, o_exp, c_exp);
      else        model_frame(16, ex ? 0 : 8, 2,  n, dd, s_exp, o_exp, c_exp);
      check("rand_handshake", 64'(ok),    64'd1);
      check("rand_sum",       s_act,      s_exp);
      check("rand_ovf",       64'(o_act), 64'(o_exp));
      check("rand_count",     c_act,      c_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
